exe_lane_occupancy: RTL and testbench

Tracks how many dispatched-but-not-yet-issued instructions each execution lane holds in the issue queue. It sits directly downstream of the execution-pipe scheduler: it consumes the per-instruction lane assignments of each dispatch bundle, counts them per lane, and subtracts per-lane issues. It produces the `backEndReady` that gates dispatch and pointer advance, so no lane ever exceeds its issue-queue share. A recovery flushes all occupancy.

---
 rtl/exe_lane_occupancy_pkg.sv | 23 ++
 rtl/exe_lane_occupancy_if.sv | 28 ++
 rtl/exe_lane_occupancy_lane_demand_count.sv | 29 ++
 rtl/exe_lane_occupancy.sv | 119 +++++++++++
 tb/tb_exe_lane_occupancy.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/exe_lane_occupancy_pkg.sv
// Shared definitions for the execution-lane occupancy tracker.
//   occ_state_e  : tracker state (RUN accepts dispatch, FLUSH drains after recovery)
//   cnt_w()      : width of a per-lane occupancy counter for a given lane depth
//   lane_idx_w() : width of a lane index; the scheduler uses the same value for
//                  its ISSUE_WIDTH_LOG, so both sides agree on exePipes width
package ExeLanePkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } occ_state_e;

  // A counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single lane still needs a 1-bit index field.
  function automatic int lane_idx_w(input int issue_width);
    return (issue_width > 1) ? $clog2(issue_width) : 1;
  endfunction

endpackage

// File: rtl/exe_lane_occupancy_if.sv
// Dispatch bundle handshake between the execution-pipe scheduler and the
// lane occupancy tracker.
//   bundleValid  : a dispatch bundle is present this cycle
//   instValid    : per-slot valid within the bundle
//   exePipes     : lane assigned to each slot
//   backEndReady : bundle accepted this cycle (advances the scheduler pointer)
// master = scheduler side, slave = occupancy tracker side.
interface exe_lane_occupancy_if #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int LANE_W         = 2
);

  logic                                   bundleValid;
  logic [DISPATCH_WIDTH-1:0]              instValid;
  logic [DISPATCH_WIDTH-1:0][LANE_W-1:0]  exePipes;
  logic                                   backEndReady;

  modport master (
    output bundleValid, instValid, exePipes,
    input  backEndReady
  );

  modport slave (
    input  bundleValid, instValid, exePipes,
    output backEndReady
  );

endinterface

// File: rtl/exe_lane_occupancy_lane_demand_count.sv
// Counts how many valid slots of a dispatch bundle target one lane.
// Purely combinational; the top instantiates one copy per lane.
//   inst_valid_i : per-slot valid
//   exe_pipes_i  : per-slot lane assignment
//   lane_idx_i   : lane this instance counts for
//   inc_o        : number of matching valid slots (0..DISPATCH_WIDTH)
module lane_demand_count #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int LANE_W         = 2,
  parameter int OUT_W          = 5
) (
  input  logic [DISPATCH_WIDTH-1:0]             inst_valid_i,
  input  logic [DISPATCH_WIDTH-1:0][LANE_W-1:0] exe_pipes_i,
  input  logic [LANE_W-1:0]                     lane_idx_i,
  output logic [OUT_W-1:0]                      inc_o
);

  always_comb begin
    // NOTE: assign a default before the loop so every path drives inc_o;
    // otherwise synthesis infers a latch.
    inc_o = '0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      if (inst_valid_i[s] && (exe_pipes_i[s] == lane_idx_i)) begin
        inc_o = inc_o + OUT_W'(1);
      end
    end
  end

endmodule

// File: rtl/exe_lane_occupancy.sv
// Per-lane issue-queue occupancy tracker.
// Counts dispatched-but-not-issued instructions per execution lane and
// produces backEndReady, which stalls a whole bundle whenever any lane would
// exceed LANE_DEPTH. A recovery flushes every count to zero.
//   clk, reset      : clock, asynchronous active-low reset
//   recoverFlag_i   : recovery broadcast; zeroes counts and enters FLUSH
//   disp_if         : dispatch bundle in, backEndReady out
//   issueValid_i    : per-lane issue of one instruction
//   laneCount_o     : registered per-lane occupancy
//   laneFull_o      : registered, lane count equals LANE_DEPTH
//   errUnderflow_o  : sticky, an issue hit an empty lane
import ExeLanePkg::*;

module exe_lane_occupancy #(
  parameter  int ISSUE_WIDTH    = 4,
  parameter  int DISPATCH_WIDTH = 4,
  parameter  int LANE_DEPTH     = 8,
  localparam int CNT_W          = cnt_w(LANE_DEPTH),
  localparam int LANE_W         = lane_idx_w(ISSUE_WIDTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               recoverFlag_i,
  exe_lane_occupancy_if.slave                disp_if,
  input  logic [ISSUE_WIDTH-1:0]             issueValid_i,
  output logic [ISSUE_WIDTH-1:0][CNT_W-1:0]  laneCount_o,
  output logic [ISSUE_WIDTH-1:0]             laneFull_o,
  output logic                               errUnderflow_o
);

  // One extra bit so count + demand cannot wrap before the depth compare.
  localparam int SUM_W = CNT_W + 1;

  occ_state_e                        state_q, state_d;
  logic [ISSUE_WIDTH-1:0][CNT_W-1:0] count_q, count_d;
  logic [ISSUE_WIDTH-1:0]            full_q, full_d;
  logic                              err_q, err_d;

  logic [ISSUE_WIDTH-1:0][SUM_W-1:0] inc;
  logic [ISSUE_WIDTH-1:0]            lane_over;
  logic [ISSUE_WIDTH-1:0]            uflow;
  logic [ISSUE_WIDTH-1:0]            dec;
  logic                              run;
  logic                              accept;

  // Lane indices >= ISSUE_WIDTH match no instance and are thus ignored.
  for (genvar l = 0; l < ISSUE_WIDTH; l++) begin : g_lane
    lane_demand_count #(
      .DISPATCH_WIDTH (DISPATCH_WIDTH),
      .LANE_W         (LANE_W),
      .OUT_W          (SUM_W)
    ) u_demand (
      .inst_valid_i (disp_if.instValid),
      .exe_pipes_i  (disp_if.exePipes),
      .lane_idx_i   (LANE_W'(l)),
      .inc_o        (inc[l])
    );

    // Same-cycle issues are not credited, keeping issueValid_i off the
    // ready path.
    assign lane_over[l] = ({1'b0, count_q[l]} + inc[l]) > SUM_W'(LANE_DEPTH);
    assign uflow[l]     = issueValid_i[l] & (count_q[l] == '0);
    assign dec[l]       = issueValid_i[l] & ~uflow[l];
  end

  assign run    = (state_q == RUN) & ~recoverFlag_i;
  assign accept = run & ~(|lane_over);

  assign disp_if.backEndReady = accept;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (recoverFlag_i) state_d = FLUSH;
      FLUSH:   state_d = recoverFlag_i ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (!run) begin
      // Recovery cycle and FLUSH ignore dispatch and issue entirely.
      count_d = '0;
    end else begin
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        count_d[l] = count_q[l]
                   + ((accept && disp_if.bundleValid) ? inc[l][CNT_W-1:0] : {CNT_W{1'b0}})
                   - CNT_W'(dec[l]);
      end
      err_d = err_q | (|uflow);
    end
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      full_d[l] = (count_d[l] == CNT_W'(LANE_DEPTH));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      count_q <= '0;
      full_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign laneCount_o    = count_q;
  assign laneFull_o     = full_q;
  assign errUnderflow_o = err_q;

endmodule

// File: tb/tb_exe_lane_occupancy.sv
// Directed bench for exe_lane_occupancy (ISSUE_WIDTH=4, DISPATCH_WIDTH=4,
// LANE_DEPTH=8). Each step drives one cycle of inputs and pushes the
// hand-computed view expected in that cycle (ready, counts, full, error)
// into a scoreboard; a monitor on the falling edge pops and compares.
module tb_exe_lane_occupancy;

  typedef int arr4_t [4];

  typedef struct {
    int    cyc;
    string name;
    bit    ready;
    arr4_t cnt;
    bit    err;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic                  recoverFlag_i;
  logic [3:0]            issueValid_i;
  logic [3:0][3:0]       laneCount_o;
  logic [3:0]            laneFull_o;
  logic                  errUnderflow_o;

  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];
  exp_t cur;

  exe_lane_occupancy_if #(.DISPATCH_WIDTH(4), .LANE_W(2)) disp_if ();

  exe_lane_occupancy #(
    .ISSUE_WIDTH    (4),
    .DISPATCH_WIDTH (4),
    .LANE_DEPTH     (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .recoverFlag_i  (recoverFlag_i),
    .disp_if        (disp_if),
    .issueValid_i   (issueValid_i),
    .laneCount_o    (laneCount_o),
    .laneFull_o     (laneFull_o),
    .errUnderflow_o (errUnderflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input string what,
                       input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s/%s got=%0d want=%0d", name, what, got, want);
    end
  endtask

  // Monitor: compare every expectation that belongs to the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      check(cur.name, "ready", 32'(disp_if.backEndReady), 32'(cur.ready));
      for (int l = 0; l < 4; l++) begin
        check(cur.name, $sformatf("cnt%0d", l), 32'(laneCount_o[l]), 32'(cur.cnt[l]));
        check(cur.name, $sformatf("full%0d", l), 32'(laneFull_o[l]), 32'(cur.cnt[l] == 8));
      end
      check(cur.name, "err", 32'(errUnderflow_o), 32'(cur.err));
    end
  end

  // Drive one cycle of inputs and queue what should be observed in it.
  task automatic step(input string name, input bit rst_v, input bit rec,
                      input bit bv, input logic [3:0] iv, input arr4_t p,
                      input logic [3:0] iss, input bit exp_ready,
                      input arr4_t exp_cnt, input bit exp_err);
    exp_t e;
    @(posedge clk);
    #1;
    reset                = rst_v;
    recoverFlag_i        = rec;
    disp_if.bundleValid  = bv;
    disp_if.instValid    = iv;
    for (int s = 0; s < 4; s++) disp_if.exePipes[s] = 2'(p[s]);
    issueValid_i         = iss;
    e.cyc   = cyc;
    e.name  = name;
    e.ready = exp_ready;
    e.cnt   = exp_cnt;
    e.err   = exp_err;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc                 = 0;
    total               = 0;
    bad                 = 0;
    reset               = 1'b0;
    recoverFlag_i       = 1'b0;
    issueValid_i        = '0;
    disp_if.bundleValid = 1'b0;
    disp_if.instValid   = '0;
    disp_if.exePipes    = '0;
    repeat (3) @(posedge clk);

    //   name          rst rec bv iv     pipes         iss    rdy cnt seen this cycle  err
    step("reset_idle",   1, 0, 0, 4'h0, '{0,0,0,0}, 4'h0, 1, '{0,0,0,0}, 0);
    step("disp_2323",    1, 0, 1, 4'hF, '{2,3,2,3}, 4'h0, 1, '{0,0,0,0}, 0);
    step("issue_l2",     1, 0, 0, 4'h0, '{0,0,0,0}, 4'h4, 1, '{0,0,2,2}, 0);
    step("after_issue",  1, 0, 0, 4'h0, '{0,0,0,0}, 4'h0, 1, '{0,0,1,2}, 0);
    // Fill lane0 to 7, then probe the depth boundary.
    step("fill0_a",      1, 0, 1, 4'hF, '{0,0,0,0}, 4'h0, 1, '{0,0,1,2}, 0);
    step("fill0_b",      1, 0, 1, 4'h7, '{0,0,0,1}, 4'h0, 1, '{4,0,1,2}, 0);
    step("ovf0_stall",   1, 0, 1, 4'h3, '{0,0,3,3}, 4'h0, 0, '{7,0,1,2}, 0);
    step("one0_accept",  1, 0, 1, 4'h1, '{0,0,0,0}, 4'h0, 1, '{7,0,1,2}, 0);
    step("lane0_full",   1, 0, 0, 4'h0, '{0,0,0,0}, 4'h0, 1, '{8,0,1,2}, 0);
    // Ready ignores bundleValid; an invalid bundle never changes counts.
    step("nobv_stall",   1, 0, 0, 4'h1, '{0,0,0,0}, 4'h0, 0, '{8,0,1,2}, 0);
    step("nobv_ready",   1, 0, 0, 4'hF, '{1,1,1,1}, 4'h0, 1, '{8,0,1,2}, 0);
    // Fill lane2 to 8, then simultaneous issue + dispatch on it.
    step("fill2_a",      1, 0, 1, 4'hF, '{2,2,2,2}, 4'h0, 1, '{8,0,1,2}, 0);
    step("fill2_b",      1, 0, 1, 4'h7, '{2,2,2,0}, 4'h0, 1, '{8,0,5,2}, 0);
    step("incdec2",      1, 0, 1, 4'h1, '{2,0,0,0}, 4'h4, 0, '{8,0,8,2}, 0);
    step("retry2",       1, 0, 1, 4'h1, '{2,0,0,0}, 4'h0, 1, '{8,0,7,2}, 0);
    step("lane2_full",   1, 0, 0, 4'h0, '{0,0,0,0}, 4'h0, 1, '{8,0,8,2}, 0);
    // Issue on empty lane1 alongside a legal issue on lane0.
    step("uflow_l1",     1, 0, 0, 4'h0, '{0,0,0,0}, 4'h3, 1, '{8,0,8,2}, 0);
    step("err_sticky",   1, 0, 0, 4'h0, '{0,0,0,0}, 4'h0, 1, '{7,0,8,2}, 1);
    // Single recovery with a valid, otherwise acceptable bundle.
    step("recover",      1, 1, 1, 4'h1, '{1,0,0,0}, 4'h1, 0, '{7,0,8,2}, 1);
    step("flush",        1, 0, 1, 4'h1, '{1,0,0,0}, 4'h0, 0, '{0,0,0,0}, 1);
    step("resume",       1, 0, 1, 4'hF, '{0,1,2,3}, 4'h0, 1, '{0,0,0,0}, 1);
    step("post_resume",  1, 0, 1, 4'hF, '{3,3,3,3}, 4'h0, 1, '{1,1,1,1}, 1);
    // Back-to-back recovery keeps FLUSH one extra cycle.
    step("recover_a",    1, 1, 0, 4'h0, '{0,0,0,0}, 4'h0, 0, '{1,1,1,5}, 1);
    step("recover_b",    1, 1, 0, 4'h0, '{0,0,0,0}, 4'h0, 0, '{0,0,0,0}, 1);
    step("flush_hold",   1, 0, 0, 4'h0, '{0,0,0,0}, 4'h0, 0, '{0,0,0,0}, 1);
    step("resume_b",     1, 0, 1, 4'h1, '{3,0,0,0}, 4'h0, 1, '{0,0,0,0}, 1);
    // Asynchronous reset mid-stream clears outputs in the same cycle.
    step("async_reset",  0, 0, 1, 4'h1, '{3,0,0,0}, 4'h0, 1, '{0,0,0,0}, 0);
    step("post_reset",   1, 0, 0, 4'h0, '{0,0,0,0}, 4'h0, 1, '{0,0,0,0}, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
